// File: rtl/wb_trace_tx.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_tx
// Purpose  : Timestamps writeback register-write events, queues them in a
//            FIFO and streams each one out as an 8-byte valid/ready frame.
// Revision : 1.0 - initial release
// ============================================================================
module wb_trace_tx #(
  parameter int DEPTH   = 8,
  parameter int RD_W    = 5,
  parameter bit SKIP_R0 = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trace_en,
  input  logic            RegWriteW,
  input  logic [RD_W-1:0] RdW,
  input  logic [31:0]     ResultW,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            overflow,
  output logic            busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 1 + 16 + RD_W + 32;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        idx, idx_nx;
  logic [15:0]       cyc;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nx;
  logic              pend_lost;
  logic [REC_W-1:0]  frame;
  logic              capture, full, empty, pop, push;

  // Record layout: {lost, cyc, rd, result}
  logic              f_lost;
  logic [15:0]       f_cyc;
  logic [RD_W-1:0]   f_rd;
  logic [31:0]       f_res;
  logic [7:0]        rd_byte;

  assign f_lost = frame[REC_W-1];
  assign f_cyc  = frame[REC_W-2 -: 16];
  assign f_rd   = frame[32 +: RD_W];
  assign f_res  = frame[31:0];

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign capture = trace_en & RegWriteW & ~(SKIP_R0 && (RdW == '0));
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push    = capture & (~full | pop);
  assign count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          idx_nx   = 3'd0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == 3'd7) begin
            idx_nx = 3'd0;
            if (!empty) pop = 1'b1;
            else        state_nx = IDLE;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cyc       <= 16'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend_lost <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      frame     <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cyc   <= cyc + 16'd1;
      count <= count_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        frame  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (capture && !push) begin
        overflow  <= 1'b1;
        pend_lost <= 1'b1;
      end else if (push) begin
        pend_lost <= 1'b0;
      end
      busy <= (count_nx != '0) || (state_nx == SEND);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pend_lost, cyc, RdW, ResultW};
  end

  always_comb begin
    rd_byte    = 8'(f_rd);
    rd_byte[7] = f_lost;
  end

  assign tx_valid = (state == SEND);

  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:    tx_data = 8'hA5;
        3'd1:    tx_data = f_cyc[15:8];
        3'd2:    tx_data = f_cyc[7:0];
        3'd3:    tx_data = rd_byte;
        3'd4:    tx_data = f_res[31:24];
        3'd5:    tx_data = f_res[23:16];
        3'd6:    tx_data = f_res[15:8];
        default: tx_data = f_res[7:0];
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_tx.sv
`default_nettype none
// Bench for wb_trace_tx: scoreboard of expected frame bytes, popped and
// compared as the sink accepts bytes.
module tb_wb_trace_tx;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            trace_en = 1'b0;
  logic            RegWriteW = 1'b0;
  logic [RD_W-1:0] RdW = '0;
  logic [31:0]     ResultW = '0;
  logic            tx_ready = 1'b0;
  logic [7:0]      tx_data, tx_data0;
  logic            tx_valid, overflow, busy;
  logic            tx_valid0, overflow0, busy0;

  int          checks = 0;
  int          failures = 0;
  int          tb_cycle = 0;
  logic [15:0] m_cyc;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          got_t[$];
  bit          sink_timeout;
  int          hold_bad;

  wb_trace_tx #(.DEPTH(8), .RD_W(RD_W), .SKIP_R0(1'b1)) u_dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overflow(overflow), .busy(busy)
  );

  wb_trace_tx #(.DEPTH(8), .RD_W(RD_W), .SKIP_R0(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .trace_en(trace_en), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .overflow(overflow0), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tb_cycle <= tb_cycle + 1;
    if (reset) m_cyc <= 16'd0;
    else       m_cyc <= m_cyc + 16'd1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frame(input logic [15:0] c, input logic [RD_W-1:0] rd,
                                     input logic [31:0] r, input logic lost);
    exp_q.push_back(8'hA5);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back({lost, 2'b00, rd});
    exp_q.push_back(r[31:24]);
    exp_q.push_back(r[23:16]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
  endfunction

  // One capture cycle; keep=0 when the main DUT must not produce a frame.
  task automatic drive_ev(input logic [RD_W-1:0] rd, input logic [31:0] r,
                          input logic lost, input bit keep);
    RegWriteW = 1'b1;
    RdW       = rd;
    ResultW   = r;
    if (keep) push_frame(m_cyc, rd, r, lost);
    step();
    RegWriteW = 1'b0;
  endtask

  // Collects accepted bytes; mode 0 = always ready, mode 1 = ready 1,0,0,...
  task automatic sink(input int nbytes, input int mode, input int budget);
    int n;
    int k;
    logic [7:0] held;
    bit stalled;
    n = 0; k = 0; held = 8'h00; stalled = 1'b0;
    sink_timeout = 1'b0;
    hold_bad = 0;
    while (n < nbytes) begin
      if (k >= budget) begin
        sink_timeout = 1'b1;
        break;
      end
      tx_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (stalled && (tx_valid !== 1'b1 || tx_data !== held)) hold_bad++;
      stalled = 1'b0;
      if (tx_valid === 1'b1) begin
        if (tx_ready) begin
          got_q.push_back(tx_data);
          got_t.push_back(tb_cycle);
          n++;
        end else begin
          stalled = 1'b1;
          held = tx_data;
        end
      end
      k++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; trace_en = 1'b1; tx_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got %02h exp 00", tx_data); end
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_flags got ovf=%b busy=%b exp 0 0", overflow, busy);
    end
    checks++;
    if (tx_valid0 !== 1'b0 || overflow0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL reset_dut0 got v=%b ovf=%b busy=%b exp 0 0 0", tx_valid0, overflow0, busy0);
    end
  endtask

  task automatic test_single();
    int k;
    logic [7:0] g, e;
    reset = 1'b0;
    k = 0;
    while (m_cyc !== 16'd3 && k < 20) begin step(); k++; end
    tx_ready = 1'b1;
    drive_ev(5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_capture_edge got v=%b busy=%b exp 0 1", tx_valid, busy);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      failures++; $display("FAIL single_latency got v=%b data=%02h exp 1 a5", tx_valid, tx_data);
    end
    sink(8, 0, 40);
    checks++;
    if (sink_timeout !== 1'b0) begin failures++; $display("FAIL single_timeout got %0d bytes exp 8", got_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 1; i < got_t.size(); i++) begin
      checks++;
      if (got_t[i] != got_t[0] + i) begin failures++; $display("FAIL single_gap byte %0d got t=%0d exp t=%0d", i, got_t[i], got_t[0] + i); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL single_byte got %02h exp %02h", g, e); end
    end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_idle got v=%b busy=%b exp 0 0", tx_valid, busy);
    end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] g, e;
    tx_ready = 1'b0;
    drive_ev(5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    sink(8, 1, 100);
    checks++;
    if (sink_timeout !== 1'b0) begin failures++; $display("FAIL bp_timeout got %0d bytes exp 8", got_q.size()); end
    checks++;
    if (hold_bad != 0) begin failures++; $display("FAIL bp_hold got %0d unstable stalls exp 0", hold_bad); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL bp_byte got %02h exp %02h", g, e); end
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle got busy=%b exp 0", busy); end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_r0();
    logic [15:0] c;
    logic [7:0]  e0 [8];
    bit          main_active;
    tx_ready = 1'b1;
    c = m_cyc;
    e0 = '{8'hA5, c[15:8], c[7:0], 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    drive_ev(5'd0, 32'h12345678, 1'b0, 1'b0);
    main_active = (busy !== 1'b0) || (tx_valid !== 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid0 !== 1'b1 || tx_data0 !== e0[i]) begin
        failures++; $display("FAIL r0_frame byte %0d got v=%b %02h exp 1 %02h", i, tx_valid0, tx_data0, e0[i]);
      end
      if (busy !== 1'b0 || tx_valid !== 1'b0) main_active = 1'b1;
      step();
    end
    checks++;
    if (main_active) begin failures++; $display("FAIL r0_filter got activity=1 exp 0"); end
    trace_en = 1'b0;
    drive_ev(5'd3, 32'h0BAD0BAD, 1'b0, 1'b0);
    step();
    checks++;
    if (busy !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL trace_en_off got busy=%b busy0=%b exp 0 0", busy, busy0);
    end
    trace_en = 1'b1;
  endtask

  task automatic test_overflow();
    logic [7:0] g, e, b3;
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      drive_ev(RD_W'(i + 1), 32'(i) * 32'h1111_1111 + 32'h0F, 1'b0, i < 9);
    checks++;
    if (overflow !== 1'b1 || tx_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_flag got ovf=%b v=%b exp 1 1", overflow, tx_valid);
    end
    sink(72, 0, 200);
    checks++;
    if (sink_timeout !== 1'b0) begin failures++; $display("FAIL ovf_timeout got %0d bytes exp 72", got_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL ovf_byte got %02h exp %02h", g, e); end
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_after_drain got busy=%b ovf=%b exp 0 1", busy, overflow);
    end
    got_q.delete(); got_t.delete(); exp_q.delete();
    tx_ready = 1'b0;
    drive_ev(5'd7, 32'hCAFEF00D, 1'b1, 1'b1);
    sink(8, 0, 40);
    checks++;
    b3 = (got_q.size() >= 4) ? got_q[3] : 8'h00;
    if (b3[7] !== 1'b1) begin failures++; $display("FAIL ovf_lost_bit got byte3=%02h exp bit7=1", b3); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL lost_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL lost_byte got %02h exp %02h", g, e); end
    end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int k;
    logic [7:0] g, e;
    tx_ready = 1'b1;
    k = 0;
    while (m_cyc !== 16'hFFFF && k < 70000) begin step(); k++; end
    checks++;
    if (m_cyc !== 16'hFFFF) begin failures++; $display("FAIL wrap_reach got cyc=%04h exp ffff", m_cyc); end
    drive_ev(5'd9,  32'hA1A2A3A4, 1'b0, 1'b1);
    drive_ev(5'd10, 32'hB1B2B3B4, 1'b0, 1'b1);
    sink(16, 0, 60);
    checks++;
    if (sink_timeout !== 1'b0) begin failures++; $display("FAIL b2b_timeout got %0d bytes exp 16", got_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 1; i < got_t.size(); i++) begin
      checks++;
      if (got_t[i] != got_t[0] + i) begin failures++; $display("FAIL b2b_gap byte %0d got t=%0d exp t=%0d", i, got_t[i], got_t[0] + i); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL b2b_byte got %02h exp %02h", g, e); end
    end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] g, e;
    tx_ready = 1'b1;
    drive_ev(5'd4, 32'h01020304, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        failures++; $display("FAIL mid_prefix byte %0d got v=%b %02h exp 1 %02h", i, tx_valid, tx_data, e);
      end
      step();
    end
    exp_q.delete();
    reset = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_reset got v=%b busy=%b data=%02h ovf=%b exp 0 0 00 0", tx_valid, busy, tx_data, overflow);
    end
    reset = 1'b0;
    k = 0;
    while (m_cyc !== 16'd2 && k < 20) begin step(); k++; end
    drive_ev(5'd6, 32'h55AA55AA, 1'b0, 1'b1);
    sink(8, 0, 40);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL mid_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL mid_byte got %02h exp %02h", g, e); end
    end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_r0();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_trace_tx.md
# wb_trace_tx

Synthesizable transmitter for the processor's writeback trace. It samples the Writeback-stage register-write events (`RegWriteW`, `RdW`, `ResultW`) and timestamps each one with a free-running cycle counter. Each event is buffered as a record in a small FIFO and streamed out as fixed 8-byte frames over a valid/ready byte interface, which an external link such as a UART or a capture buffer can drain. The block sits beside the datapath in `top`, taps the W-stage signals read-only, and never stalls the pipeline.

## Interface
- `DEPTH`, 8: FIFO capacity in records; power of two, ≥2.
- `RD_W`, 5: width of `RdW`; ≤7.
- `SKIP_R0`, 1: when 1, writes with `RdW`==0 are not traced.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears FIFO, FSM, counter, flags.
- `trace_en` in 1: capture enable, sampled each edge.
- `RegWriteW` in 1: W-stage register write strobe.
- `RdW` in `RD_W`: W-stage destination register.
- `ResultW` in 32: W-stage write data.
- `tx_data` out 8: current frame byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts byte when high with `tx_valid`.
- `overflow` out 1: sticky; at least one record was dropped since reset.
- `busy` out 1: FIFO non-empty or frame in progress.

## Operation
- **Cycle counter `cyc`:** 16 bits. It is 0 on the first edge with `reset` low, increments every edge after that, and wraps from 0xFFFF to 0x0000.
- **Capture condition:** at an edge, a record is captured when `trace_en & RegWriteW & !(SKIP_R0 && RdW==0)`. The record holds {`cyc`, `RdW`, `ResultW`, lost}, where `cyc` is the value before that edge's increment.
- **lost bit:** set in a record when one or more earlier records were dropped since the last record was accepted. The pending-lost flag clears when a record carrying lost=1 is written.
- **Push when full:** the record is dropped and `overflow` and pending-lost are set. Exception: if a pop occurs on the same edge, the push succeeds.
- **Frame format, byte order 0..7:**
  - 0: 0xA5
  - 1: `cyc[15:8]`
  - 2: `cyc[7:0]`
  - 3: {lost, zero-pad, `RdW`}, i.e. bit7 = lost, low `RD_W` bits = `RdW`
  - 4–7: `ResultW[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`
- **FSM:**
  - IDLE: if the FIFO is non-empty, pop the head into the frame register, set idx=0, and go to SEND. Otherwise stay.
  - SEND: `tx_valid`=1 and `tx_data`=byte[idx]. On a handshake with idx<7, idx increments. On a handshake with idx=7: if the FIFO is non-empty, pop and load the next frame with idx=0 and stay in SEND (back-to-back, no bubble); else go to IDLE.
- **Hold rule:** `tx_data` stays stable while `tx_valid & !tx_ready`. `tx_valid` never drops mid-frame.
- **`trace_en` low:** captures stop. Queued records and the frame in progress still drain.

## Timing
- **Reset values:** `tx_valid`=0, `tx_data`=0x00, `overflow`=0, `busy`=0, FSM=IDLE, FIFO empty, `cyc`=0, pending-lost=0.
- **Reset mid-frame:** the frame is abandoned immediately and `tx_valid` is 0 after the reset edge. No partial-frame completion.
- **Latency from idle:** an event captured at edge E gives `tx_valid`=1 with byte 0 after edge E+1.
- **Throughput:** one byte per cycle while `tx_ready`=1, so 8 cycles per frame. Sustained capture faster than 1 per 8 cycles eventually overflows.
- **FIFO occupancy:** the frame register is not counted. DEPTH records queue plus one frame in flight.
- **`busy`** is registered. It is 1 after any edge that leaves the FIFO non-empty or FSM=SEND.

## Test plan
- **Single event:** deassert reset, then at `cyc`=3 drive `RegWriteW`=1, `RdW`=5, `ResultW`=0xDEADBEEF with `tx_ready`=1. Required: bytes A5 00 03 05 DE AD BE EF on 8 consecutive cycles, with `tx_valid` first high after the following edge.
- **Backpressure:** same event with `tx_ready` toggling 1,0,0,1,... Required: the same 8 bytes in order, `tx_data` stable during every stalled cycle, and no duplicated or lost byte.
- **R0 filter:** `RdW`=0 write with `SKIP_R0`=1 → no frame and `busy` stays 0. With `SKIP_R0`=0 → a frame with byte3=0x00.
- **Overflow:** hold `tx_ready`=0 and capture 10 events on consecutive cycles with DEPTH=8. Required: `overflow`=1; after release, 9 frames emerge (1 in flight + 8 queued). Then capture one more event: its byte3 has bit7=1.
- **Back-to-back and wrap:** run until `cyc` nears 0xFFFF, capture events at `cyc` 0xFFFF and 0x0000. Required: two contiguous frames with no idle cycle between byte 7 and the next A5, carrying timestamps FF FF and 00 00.
- **Reset mid-frame:** assert `reset` after byte 3 is accepted. Required: `tx_valid`=0 and `busy`=0 after the reset edge, and the next frame starts with A5 and `cyc` relative to the new reset.
